// File: rtl/apu_voice_mixer.sv
// Multi-channel voice mixer: per-channel ADSR-style gain envelopes
// feeding a serial multiply-accumulate with a valid/ready output.
module apu_voice_mixer #(
    parameter int NUM_CHAN = 4,
    parameter int SAMP_W   = 8,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CHAN*SAMP_W-1:0]   samp_in,
    input  logic [NUM_CHAN-1:0]          gate,
    input  logic [NUM_CHAN-1:0]          mute,
    input  logic                         sample_tick,
    input  logic                         env_tick,
    input  logic                         samp_ready,
    output logic [OUT_W-1:0]             samp_out,
    output logic                         samp_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_CHAN*VOL_W-1:0]    gain_dbg
);

    localparam int CNT_W = $clog2(NUM_CHAN);
    localparam int ACC_W = SAMP_W + VOL_W + CNT_W;
    localparam int SHIFT = OUT_W - ACC_W;

    localparam logic [VOL_W-1:0] GMAX = '1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHAN - 1);

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_t;

    typedef enum logic [1:0] {
        MIX_IDLE,
        MIX_ACCUM,
        MIX_OUTPUT
    } mix_t;

    env_t             r_env     [NUM_CHAN];
    env_t             w_env_nx  [NUM_CHAN];
    logic [VOL_W-1:0] r_gain    [NUM_CHAN];
    logic [VOL_W-1:0] w_gain_nx [NUM_CHAN];

    logic [NUM_CHAN-1:0] r_gate_q;
    logic [NUM_CHAN-1:0] w_rise;

    assign w_rise = gate & ~r_gate_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate_q <= '0;
            for (int k = 0; k < NUM_CHAN; k++) begin
                r_env[k]  <= ENV_IDLE;
                r_gain[k] <= '0;
            end
        end else begin
            r_gate_q <= gate;
            for (int k = 0; k < NUM_CHAN; k++) begin
                r_env[k]  <= w_env_nx[k];
                r_gain[k] <= w_gain_nx[k];
            end
        end
    end

    // Gate transitions resolve first; the envelope step then uses the new state.
    always_comb begin
        for (int k = 0; k < NUM_CHAN; k++) begin
            w_env_nx[k]  = r_env[k];
            w_gain_nx[k] = r_gain[k];

            if (w_rise[k]) begin
                w_env_nx[k] = ENV_ATTACK;
            end else if (!gate[k] &&
                         (r_env[k] == ENV_ATTACK ||
                          r_env[k] == ENV_SUSTAIN)) begin
                w_env_nx[k] = ENV_RELEASE;
            end

            if (env_tick) begin
                if (w_env_nx[k] == ENV_ATTACK) begin
                    if (r_gain[k] != GMAX) begin
                        w_gain_nx[k] = r_gain[k] + 1'b1;
                    end
                    if (w_gain_nx[k] == GMAX) begin
                        w_env_nx[k] = ENV_SUSTAIN;
                    end
                end else if (w_env_nx[k] == ENV_RELEASE &&
                             r_gain[k] != '0) begin
                    w_gain_nx[k] = r_gain[k] - 1'b1;
                end
            end

            if (w_env_nx[k] == ENV_RELEASE && w_gain_nx[k] == '0) begin
                w_env_nx[k] = ENV_IDLE;
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < NUM_CHAN; gk++) begin : g_dbg
            assign gain_dbg[gk*VOL_W +: VOL_W] = r_gain[gk];
        end
    endgenerate

    mix_t r_mix;
    mix_t w_mix_nx;

    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_prod;
    logic [ACC_W-1:0]    w_term;
    logic [ACC_W-1:0]    w_sum;
    logic [SAMP_W-1:0]   r_samp  [NUM_CHAN];
    logic [VOL_W-1:0]    r_gsnap [NUM_CHAN];
    logic [NUM_CHAN-1:0] r_mute;
    logic [OUT_W-1:0]    r_out;
    logic                r_ovr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mix <= MIX_IDLE;
        end else begin
            r_mix <= w_mix_nx;
        end
    end

    always_comb begin
        w_mix_nx   = r_mix;
        samp_valid = 1'b0;
        busy       = 1'b1;
        unique case (r_mix)
            MIX_IDLE: begin
                busy = 1'b0;
                if (sample_tick) begin
                    w_mix_nx = MIX_ACCUM;
                end
            end
            MIX_ACCUM: begin
                if (r_cnt == LAST) begin
                    w_mix_nx = MIX_OUTPUT;
                end
            end
            MIX_OUTPUT: begin
                samp_valid = 1'b1;
                if (samp_ready) begin
                    w_mix_nx = MIX_IDLE;
                end
            end
            default: begin
                w_mix_nx = MIX_IDLE;
            end
        endcase
    end

    assign w_prod = ACC_W'(r_samp[r_cnt]) * ACC_W'(r_gsnap[r_cnt]);
    assign w_term = r_mute[r_cnt] ? '0 : w_prod;
    assign w_sum  = r_acc + w_term;

    // One channel per ACCUM cycle; result is left-aligned into samp_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_ovr  <= 1'b0;
            r_mute <= '0;
            for (int k = 0; k < NUM_CHAN; k++) begin
                r_samp[k]  <= '0;
                r_gsnap[k] <= '0;
            end
        end else begin
            if (sample_tick && r_mix != MIX_IDLE) begin
                r_ovr <= 1'b1;
            end
            if (r_mix == MIX_IDLE && sample_tick) begin
                r_acc  <= '0;
                r_cnt  <= '0;
                r_mute <= mute;
                for (int k = 0; k < NUM_CHAN; k++) begin
                    r_samp[k]  <= samp_in[k*SAMP_W +: SAMP_W];
                    r_gsnap[k] <= r_gain[k];
                end
            end else if (r_mix == MIX_ACCUM) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_out <= OUT_W'(w_sum) << SHIFT;
                end
            end
        end
    end

    assign samp_out = r_out;
    assign overrun  = r_ovr;

endmodule

// File: tb/tb_apu_voice_mixer.sv
// Self-checking bench for apu_voice_mixer: directed scenarios plus
// randomized traffic against a behavioural envelope/mix model.
module tb_apu_voice_mixer;

    localparam int NC  = 4;
    localparam int SW  = 8;
    localparam int VW  = 4;
    localparam int OW  = 16;
    localparam int ACC = SW + VW + $clog2(NC);
    localparam int GM  = (1 << VW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC*SW-1:0] samp_in;
    logic [NC-1:0]    gate;
    logic [NC-1:0]    mute;
    logic             sample_tick;
    logic             env_tick;
    logic             samp_ready;
    logic [OW-1:0]    samp_out;
    logic             samp_valid;
    logic             busy;
    logic             overrun;
    logic [NC*VW-1:0] gain_dbg;

    apu_voice_mixer #(
        .NUM_CHAN (NC),
        .SAMP_W   (SW),
        .VOL_W    (VW),
        .OUT_W    (OW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .samp_in     (samp_in),
        .gate        (gate),
        .mute        (mute),
        .sample_tick (sample_tick),
        .env_tick    (env_tick),
        .samp_ready  (samp_ready),
        .samp_out    (samp_out),
        .samp_valid  (samp_valid),
        .busy        (busy),
        .overrun     (overrun),
        .gain_dbg    (gain_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Envelope phase: 0 idle, 1 attack, 2 sustain, 3 release
    int            m_ph [NC];
    int            m_g  [NC];
    bit            m_gq [NC];
    bit            m_run;
    int            m_wait;
    bit            m_valid;
    bit            m_ovr;
    logic [OW-1:0] m_pend;
    logic [OW-1:0] m_out;

    function automatic logic [OW-1:0] model_mix();
        longint s = 0;
        for (int k = 0; k < NC; k++) begin
            if (!mute[k]) s += longint'(samp_in[k*SW +: SW]) * m_g[k];
        end
        return OW'(s << (OW - ACC));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_ph[k] = 0;
            m_g[k]  = 0;
            m_gq[k] = 0;
        end
        m_run   = 0;
        m_wait  = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_pend  = '0;
        m_out   = '0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (sample_tick) begin
                m_pend = model_mix();
                m_run  = 1;
                m_wait = NC;
            end
        end else begin
            if (sample_tick) m_ovr = 1;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1;
                    m_out   = m_pend;
                end
            end else if (samp_ready) begin
                m_valid = 0;
                m_run   = 0;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (gate[k] && !m_gq[k]) m_ph[k] = 1;
            else if (!gate[k] && (m_ph[k] == 1 || m_ph[k] == 2)) m_ph[k] = 3;
            if (env_tick) begin
                if (m_ph[k] == 1) begin
                    m_g[k] = (m_g[k] + 1 > GM) ? GM : m_g[k] + 1;
                    if (m_g[k] == GM) m_ph[k] = 2;
                end else if (m_ph[k] == 3) begin
                    m_g[k] = (m_g[k] - 1 < 0) ? 0 : m_g[k] - 1;
                end
            end
            if (m_ph[k] == 3 && m_g[k] == 0) m_ph[k] = 0;
            m_gq[k] = gate[k];
        end
    endtask

    task automatic cyc();
        logic [NC*VW-1:0] eg;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < NC; k++) eg[k*VW +: VW] = VW'(m_g[k]);
        check("valid", {63'd0, samp_valid}, {63'd0, m_valid});
        check("busy", {63'd0, busy}, {63'd0, m_run});
        check("overrun", {63'd0, overrun}, {63'd0, m_ovr});
        check("samp_out", 64'(samp_out), 64'(m_out));
        check("gain_dbg", 64'(gain_dbg), 64'(eg));
    endtask

    task automatic ticks(input int n);
        env_tick = 1'b1;
        repeat (n) cyc();
        env_tick = 1'b0;
    endtask

    task automatic take(output int lat, output logic [OW-1:0] val);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        lat = 1;
        while (!samp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        val = samp_out;
    endtask

    int            lat;
    int            nv;
    logic [OW-1:0] val;
    logic [OW-1:0] held;

    initial begin
        model_reset();
        reset       = 1'b1;
        samp_in     = '0;
        gate        = '0;
        mute        = '0;
        sample_tick = 1'b0;
        env_tick    = 1'b0;
        samp_ready  = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_out", 64'(samp_out), 64'd0);
        check("rst_valid", {63'd0, samp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovr", {63'd0, overrun}, 64'd0);
        check("rst_gain", 64'(gain_dbg), 64'd0);

        // Attack ramp, sustain hold, release ramp on channel 0
        gate = 4'b0001;
        cyc();
        check("atk_start", 64'(gain_dbg[VW-1:0]), 64'd0);
        for (int i = 1; i <= 15; i++) begin
            env_tick = 1'b1;
            cyc();
            env_tick = 1'b0;
            check("atk_step", 64'(gain_dbg[VW-1:0]), 64'(i));
            cyc();
        end
        ticks(3);
        check("sus_hold", 64'(gain_dbg[VW-1:0]), 64'd15);
        gate = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            env_tick = 1'b1;
            cyc();
            env_tick = 1'b0;
            check("rel_step", 64'(gain_dbg[VW-1:0]), 64'(15 - i));
        end
        ticks(2);
        check("rel_floor", 64'(gain_dbg[VW-1:0]), 64'd0);

        // Single channel at full gain
        gate = 4'b0001;
        cyc();
        ticks(15);
        samp_in = '1;
        take(lat, val);
        check("lat_single", 64'(lat), 64'd5);
        check("mix_single", 64'(val), 64'd15300);
        cyc();

        // All channels at full gain, then with channel 1 muted
        gate = 4'b1111;
        cyc();
        ticks(15);
        check("all_gain", 64'(gain_dbg), 64'hFFFF);
        take(lat, val);
        check("mix_all", 64'(val), 64'd61200);
        cyc();
        mute = 4'b0010;
        take(lat, val);
        check("mix_mute", 64'(val), 64'd45900);
        cyc();
        mute = 4'b0000;

        // Back-pressure with a dropped tick
        samp_ready = 1'b0;
        take(lat, held);
        check("bp_val", 64'(held), 64'd61200);
        for (int i = 0; i < 10; i++) begin
            sample_tick = (i == 3);
            cyc();
            check("bp_stable", 64'(samp_out), 64'(held));
            check("bp_busy", {63'd0, busy}, 64'd1);
        end
        sample_tick = 1'b0;
        check("bp_ovr", {63'd0, overrun}, 64'd1);
        samp_ready = 1'b1;
        cyc();
        check("bp_done", {63'd0, samp_valid}, 64'd0);
        nv = 0;
        repeat (8) begin
            cyc();
            nv += int'(samp_valid);
        end
        check("bp_noextra", 64'(nv), 64'd0);

        // Release from mid-attack, then re-gate during release
        reset = 1'b1;
        gate  = '0;
        cyc();
        reset = 1'b0;
        gate  = 4'b0001;
        cyc();
        ticks(7);
        check("mid_atk", 64'(gain_dbg[VW-1:0]), 64'd7);
        gate = 4'b0000;
        cyc();
        check("rel_from7", 64'(gain_dbg[VW-1:0]), 64'd7);
        ticks(4);
        check("rel_at3", 64'(gain_dbg[VW-1:0]), 64'd3);
        gate = 4'b0001;
        cyc();
        check("regate", 64'(gain_dbg[VW-1:0]), 64'd3);
        ticks(1);
        check("regate_step", 64'(gain_dbg[VW-1:0]), 64'd4);

        // Reset during the second ACCUM cycle; gate held high across it
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc();
        check("acc_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_out", 64'(samp_out), 64'd0);
        check("abort_valid", {63'd0, samp_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_gain", 64'(gain_dbg), 64'd0);
        ticks(1);
        check("rst_edge", 64'(gain_dbg[VW-1:0]), 64'd1);
        nv = 0;
        repeat (8) begin
            cyc();
            nv += int'(samp_valid);
        end
        check("abort_noval", 64'(nv), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 599) == 0);
            samp_in     = $urandom;
            mute        = NC'($urandom);
            env_tick    = ($urandom_range(0, 2) == 0);
            sample_tick = ($urandom_range(0, 7) == 0);
            samp_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                gate[$urandom_range(0, NC - 1)] ^= 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
